// File: rtl/vga_pkg.sv
// Shared constants for the VGA timing controller.
// Holds the 640x480@60 default timing, the derived line/frame totals,
// the width of the position counters and a helper that sums the four
// segments of one scan axis (active + front porch + sync + back porch).
package vga_pkg;

  // Position counters are 10 bits wide, so an axis may hold at most 1024 steps.
  localparam int CNT_W     = 10;
  localparam int MAX_TOTAL = 1024;

  // Prescaler is 4 bits wide, enough for up to 16 clk cycles per pixel.
  localparam int PRE_W       = 4;
  localparam int MAX_CLK_DIV = 16;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_CLK_DIV = 4;

  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_axis_counter.sv
// One scan-axis position counter.
// Counts 0..TOTAL-1 on each cycle where en is high and wraps back to 0.
// carry is high (combinationally) on the enabled cycle that performs the
// wrap, so it can enable the next axis.
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous, active-low
//   en     - advance the count this cycle
//   count  - current position (CNT_W bits)
//   carry  - en && count == TOTAL-1
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int TOTAL = DEF_H_TOTAL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             carry
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  assign carry = en && (count == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (en) begin
      count <= carry ? '0 : count + ONE;
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing controller.
// A prescaler divides clk down to the pixel rate; two axis counters track
// the horizontal and vertical position. The positions are decoded into
// sync, blanking and marker signals and every output is registered in a
// single stage, so all outputs describe the counter state of the previous
// clk and stay mutually aligned.
// Ports:
//   clk          - system clock, rising edge
//   reset        - asynchronous, active-low
//   red/green/blue - pixel colour for the current position (COLOR_W each)
//   blank        - forces rgb to zero, timing unaffected
//   hsync/vsync  - sync pulses, active level HS_POL / VS_POL
//   rgb          - {red,green,blue} inside the visible area, else 0
//   pixel_x/pixel_y - current position, zero-extended to 10 bits
//   video_on     - position is inside the visible area
//   pixel_tick   - first clk of each pixel
//   line_start   - first clk of pixel 0 of a line
//   frame_start  - first clk of pixel (0,0)
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int COLOR_W  = 1,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [COLOR_W-1:0]     red,
  input  logic [COLOR_W-1:0]     green,
  input  logic [COLOR_W-1:0]     blue,
  input  logic                   blank,
  output logic                   hsync,
  output logic                   vsync,
  output logic [3*COLOR_W-1:0]   rgb,
  output logic [CNT_W-1:0]       pixel_x,
  output logic [CNT_W-1:0]       pixel_y,
  output logic                   video_on,
  output logic                   pixel_tick,
  output logic                   line_start,
  output logic                   frame_start
);

  localparam int H_TOTAL  = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL  = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  // Reject geometries the 10-bit counters or 4-bit prescaler cannot hold.
  if (H_TOTAL > MAX_TOTAL) begin : g_bad_h_total
    $error("vga_timing_ctrl: H_TOTAL %0d exceeds %0d", H_TOTAL, MAX_TOTAL);
  end
  if (V_TOTAL > MAX_TOTAL) begin : g_bad_v_total
    $error("vga_timing_ctrl: V_TOTAL %0d exceeds %0d", V_TOTAL, MAX_TOTAL);
  end
  if (CLK_DIV < 1 || CLK_DIV > MAX_CLK_DIV) begin : g_bad_clk_div
    $error("vga_timing_ctrl: CLK_DIV %0d outside 1..%0d", CLK_DIV, MAX_CLK_DIV);
  end

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

  logic [PRE_W-1:0] prescaler;
  logic             tick;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_wrap;
  // Nothing downstream needs the end-of-frame carry of the vertical axis.
  logic             unused_v_wrap;

  // With CLK_DIV=1 the prescaler stays at 0 and tick is high every clk.
  assign tick = (prescaler == PRE_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler <= '0;
    end else begin
      prescaler <= tick ? '0 : prescaler + PRE_ONE;
    end
  end

  vga_axis_counter #(
    .TOTAL (H_TOTAL)
  ) u_h_counter (
    .clk   (clk),
    .reset (reset),
    .en    (tick),
    .count (h_cnt),
    .carry (h_wrap)
  );

  vga_axis_counter #(
    .TOTAL (V_TOTAL)
  ) u_v_counter (
    .clk   (clk),
    .reset (reset),
    .en    (h_wrap),
    .count (v_cnt),
    .carry (unused_v_wrap)
  );

  // Compare on 11 bits so a boundary equal to 1024 does not wrap to 0.
  logic [CNT_W:0] h_ext;
  logic [CNT_W:0] v_ext;
  logic           von_d;
  logic           hs_d;
  logic           vs_d;
  logic           first_clk;
  logic           ls_d;
  logic           fs_d;

  always_comb begin
    h_ext     = {1'b0, h_cnt};
    v_ext     = {1'b0, v_cnt};
    von_d     = (h_ext < (CNT_W+1)'(H_ACTIVE)) && (v_ext < (CNT_W+1)'(V_ACTIVE));
    hs_d      = ((h_ext >= (CNT_W+1)'(HS_START)) && (h_ext < (CNT_W+1)'(HS_END)))
                ? HS_POL : ~HS_POL;
    vs_d      = ((v_ext >= (CNT_W+1)'(VS_START)) && (v_ext < (CNT_W+1)'(VS_END)))
                ? VS_POL : ~VS_POL;
    first_clk = (prescaler == '0);
    ls_d      = first_clk && (h_cnt == '0);
    fs_d      = ls_d && (v_cnt == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixel_x     <= '0;
      pixel_y     <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      video_on    <= 1'b0;
      rgb         <= '0;
      pixel_tick  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pixel_x     <= h_cnt;
      pixel_y     <= v_cnt;
      hsync       <= hs_d;
      vsync       <= vs_d;
      video_on    <= von_d;
      rgb         <= (von_d && !blank) ? {red, green, blue} : '0;
      pixel_tick  <= first_clk;
      line_start  <= ls_d;
      frame_start <= fs_d;
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl. Three instances share one clock:
//   d_* : default 640x480 timing, CLK_DIV=4, COLOR_W=1
//   s_* : reduced timing H 8/2/3/2, V 4/1/1/1, CLK_DIV=1, COLOR_W=2
//   p_* : reduced timing, CLK_DIV=3, COLOR_W=2, HS_POL=VS_POL=1
// The reference model maps "k-th clk edge after reset release" straight to
// a screen position with division/modulo and decodes outputs from the
// timing rules.
module tb_vga_timing_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       von;
    logic       pt;
    logic       ls;
    logic       fs;
  } tim_t;

  // ---------------- default instance ----------------
  logic       d_reset = 1'b0;
  logic       d_red = 1'b0, d_green = 1'b0, d_blue = 1'b0, d_blank = 1'b0;
  logic       d_hsync, d_vsync, d_video_on, d_pixel_tick, d_line_start, d_frame_start;
  logic [2:0] d_rgb;
  logic [9:0] d_pixel_x, d_pixel_y;
  tim_t       d_obs;
  assign d_obs = {d_pixel_x, d_pixel_y, d_hsync, d_vsync, d_video_on,
                  d_pixel_tick, d_line_start, d_frame_start};

  vga_timing_ctrl u_dut_def (
    .clk (clk), .reset (d_reset),
    .red (d_red), .green (d_green), .blue (d_blue), .blank (d_blank),
    .hsync (d_hsync), .vsync (d_vsync), .rgb (d_rgb),
    .pixel_x (d_pixel_x), .pixel_y (d_pixel_y), .video_on (d_video_on),
    .pixel_tick (d_pixel_tick), .line_start (d_line_start), .frame_start (d_frame_start)
  );

  // ---------------- small instance ----------------
  logic       s_reset = 1'b0;
  logic [1:0] s_red = '0, s_green = '0, s_blue = '0;
  logic       s_blank = 1'b0;
  logic       s_hsync, s_vsync, s_video_on, s_pixel_tick, s_line_start, s_frame_start;
  logic [5:0] s_rgb;
  logic [9:0] s_pixel_x, s_pixel_y;
  tim_t       s_obs;
  assign s_obs = {s_pixel_x, s_pixel_y, s_hsync, s_vsync, s_video_on,
                  s_pixel_tick, s_line_start, s_frame_start};

  vga_timing_ctrl #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .CLK_DIV (1), .COLOR_W (2)
  ) u_dut_small (
    .clk (clk), .reset (s_reset),
    .red (s_red), .green (s_green), .blue (s_blue), .blank (s_blank),
    .hsync (s_hsync), .vsync (s_vsync), .rgb (s_rgb),
    .pixel_x (s_pixel_x), .pixel_y (s_pixel_y), .video_on (s_video_on),
    .pixel_tick (s_pixel_tick), .line_start (s_line_start), .frame_start (s_frame_start)
  );

  // ---------------- inverted-polarity instance ----------------
  logic       p_reset = 1'b0;
  logic [1:0] p_red = '0, p_green = '0, p_blue = '0;
  logic       p_blank = 1'b0;
  logic       p_hsync, p_vsync, p_video_on, p_pixel_tick, p_line_start, p_frame_start;
  logic [5:0] p_rgb;
  logic [9:0] p_pixel_x, p_pixel_y;
  tim_t       p_obs;
  assign p_obs = {p_pixel_x, p_pixel_y, p_hsync, p_vsync, p_video_on,
                  p_pixel_tick, p_line_start, p_frame_start};

  vga_timing_ctrl #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .CLK_DIV (3), .COLOR_W (2), .HS_POL (1'b1), .VS_POL (1'b1)
  ) u_dut_pol (
    .clk (clk), .reset (p_reset),
    .red (p_red), .green (p_green), .blue (p_blue), .blank (p_blank),
    .hsync (p_hsync), .vsync (p_vsync), .rgb (p_rgb),
    .pixel_x (p_pixel_x), .pixel_y (p_pixel_y), .video_on (p_video_on),
    .pixel_tick (p_pixel_tick), .line_start (p_line_start), .frame_start (p_frame_start)
  );

  // ---------------- reference model ----------------
  // k = number of rising edges since release; edge k shows the counter
  // state reached after k clks, i.e. pixel k/d, prescaler phase k%d.
  function automatic tim_t model(input int k, input int d,
                                 input int ha, input int hf, input int hsw, input int hb,
                                 input int va, input int vf, input int vsw, input int vb,
                                 input logic hp, input logic vp);
    tim_t m;
    int   ht, vt, pix, pre, h, v;
    ht    = ha + hf + hsw + hb;
    vt    = va + vf + vsw + vb;
    pix   = k / d;
    pre   = k % d;
    h     = pix % ht;
    v     = (pix / ht) % vt;
    m.x   = 10'(h);
    m.y   = 10'(v);
    m.hs  = (h >= ha + hf && h < ha + hf + hsw) ? hp : ~hp;
    m.vs  = (v >= va + vf && v < va + vf + vsw) ? vp : ~vp;
    m.von = (h < ha) && (v < va);
    m.pt  = (pre == 0);
    m.ls  = (pre == 0) && (h == 0);
    m.fs  = m.ls && (v == 0);
    return m;
  endfunction

  function automatic tim_t model_def(input int k);
    return model(k, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
  endfunction

  function automatic tim_t model_small(input int k);
    return model(k, 1, 8, 2, 3, 2, 4, 1, 1, 1, 1'b0, 1'b0);
  endfunction

  function automatic tim_t model_pol(input int k);
    return model(k, 3, 8, 2, 3, 2, 4, 1, 1, 1, 1'b1, 1'b1);
  endfunction

  function automatic tim_t reset_vals(input logic hp, input logic vp);
    tim_t m;
    m    = '0;
    m.hs = ~hp;
    m.vs = ~vp;
    return m;
  endfunction

  task automatic rand_small();
    s_red   = 2'($urandom_range(0, 3));
    s_green = 2'($urandom_range(0, 3));
    s_blue  = 2'($urandom_range(0, 3));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    tim_t e;
    repeat (3) @(negedge clk);
    e = reset_vals(1'b0, 1'b0);
    checks++;
    if (d_obs !== e) begin
      errors++;
      $display("FAIL reset_def got %h exp %h", d_obs, e);
    end
    checks++;
    if (s_obs !== e) begin
      errors++;
      $display("FAIL reset_small got %h exp %h", s_obs, e);
    end
    e = reset_vals(1'b1, 1'b1);
    checks++;
    if (p_obs !== e || p_hsync !== 1'b0 || p_vsync !== 1'b0) begin
      errors++;
      $display("FAIL reset_pol got %h exp %h", p_obs, e);
    end
    checks++;
    if (d_rgb !== 3'd0 || s_rgb !== 6'd0 || p_rgb !== 6'd0) begin
      errors++;
      $display("FAIL reset_rgb got %h/%h/%h exp 0/0/0", d_rgb, s_rgb, p_rgb);
    end
  endtask

  task automatic test_default_line();
    tim_t     e;
    logic [2:0] erg;
    int       hs_low = 0;
    int       vs_low = 0;
    int       ls_k[$];
    @(negedge clk);
    d_red = 1'b1; d_green = 1'b0; d_blue = 1'b1; d_blank = 1'b0;
    d_reset = 1'b1;
    for (int k = 0; k < 6500; k++) begin
      @(negedge clk);
      e   = model_def(k);
      erg = (e.von && !d_blank) ? {d_red, d_green, d_blue} : 3'd0;
      checks++;
      if (d_obs !== e || d_rgb !== erg) begin
        errors++;
        $display("FAIL default_model k=%0d got %h/%h exp %h/%h", k, d_obs, d_rgb, e, erg);
      end
      if (k < 3200 && d_hsync === 1'b0) hs_low++;
      if (d_vsync === 1'b0) vs_low++;
      if (d_line_start === 1'b1) ls_k.push_back(k);
      d_red   = 1'($urandom_range(0, 1));
      d_green = 1'($urandom_range(0, 1));
      d_blue  = 1'($urandom_range(0, 1));
      d_blank = ($urandom_range(0, 7) == 0);
    end
    checks++;
    if (hs_low !== 384) begin
      errors++;
      $display("FAIL default_hsync_width got %0d exp 384", hs_low);
    end
    checks++;
    if (ls_k.size() < 2 || (ls_k[1] - ls_k[0]) !== 3200) begin
      errors++;
      $display("FAIL default_line_period got %0d pulses first gap %0d exp 3200",
               ls_k.size(), (ls_k.size() < 2) ? 0 : ls_k[1] - ls_k[0]);
    end
    checks++;
    if (vs_low !== 0) begin
      errors++;
      $display("FAIL default_vsync_early got %0d low clks exp 0", vs_low);
    end
    d_reset = 1'b0;
  endtask

  task automatic test_small_frame();
    tim_t       e;
    logic [5:0] erg;
    int         fs_k[$];
    int         von_cnt = 0;
    int         hs_min = 1000;
    int         hs_max = -1;
    @(negedge clk);
    s_reset = 1'b0;
    @(negedge clk);
    rand_small();
    s_blank = 1'b0;
    s_reset = 1'b1;
    for (int k = 0; k < 220; k++) begin
      @(negedge clk);
      e   = model_small(k);
      erg = (e.von && !s_blank) ? {s_red, s_green, s_blue} : 6'd0;
      checks++;
      if (s_obs !== e || s_rgb !== erg) begin
        errors++;
        $display("FAIL small_model k=%0d got %h/%h exp %h/%h", k, s_obs, s_rgb, e, erg);
      end
      if (s_frame_start === 1'b1) fs_k.push_back(k);
      if (k < 105 && s_video_on === 1'b1) von_cnt++;
      if (k < 15 && s_hsync === 1'b0) begin
        if (int'(s_pixel_x) < hs_min) hs_min = int'(s_pixel_x);
        if (int'(s_pixel_x) > hs_max) hs_max = int'(s_pixel_x);
      end
      rand_small();
    end
    checks++;
    if (fs_k.size() < 2 || (fs_k[1] - fs_k[0]) !== 105) begin
      errors++;
      $display("FAIL small_frame_period got %0d pulses first gap %0d exp 105",
               fs_k.size(), (fs_k.size() < 2) ? 0 : fs_k[1] - fs_k[0]);
    end
    checks++;
    if (von_cnt !== 32) begin
      errors++;
      $display("FAIL small_video_on_count got %0d exp 32", von_cnt);
    end
    checks++;
    if (hs_min !== 10 || hs_max !== 12) begin
      errors++;
      $display("FAIL small_hsync_span got %0d..%0d exp 10..12", hs_min, hs_max);
    end
  endtask

  task automatic test_blank();
    tim_t       e;
    logic [5:0] erg;
    int         blank_rgb_nz = 0;
    @(negedge clk);
    s_reset = 1'b0;
    @(negedge clk);
    rand_small();
    s_blank = 1'b0;
    s_reset = 1'b1;
    for (int k = 0; k < 105; k++) begin
      @(negedge clk);
      e   = model_small(k);
      erg = (e.von && !s_blank) ? {s_red, s_green, s_blue} : 6'd0;
      checks++;
      if (s_obs !== e || s_rgb !== erg) begin
        errors++;
        $display("FAIL blank_model k=%0d got %h/%h exp %h/%h", k, s_obs, s_rgb, e, erg);
      end
      if (k >= 15 && k < 30 && s_rgb !== 6'd0) blank_rgb_nz++;
      rand_small();
      // Line 1 occupies edges 15..29; blank covers exactly that line.
      s_blank = (k + 1 >= 15) && (k + 1 < 30);
    end
    s_blank = 1'b0;
    checks++;
    if (blank_rgb_nz !== 0) begin
      errors++;
      $display("FAIL blank_line_rgb got %0d nonzero clks exp 0", blank_rgb_nz);
    end
  endtask

  task automatic test_reset_midline();
    tim_t       e;
    logic [5:0] erg;
    @(negedge clk);
    s_reset = 1'b0;
    @(negedge clk);
    rand_small();
    s_reset = 1'b1;
    for (int k = 0; k <= 35; k++) begin
      @(negedge clk);
      e   = model_small(k);
      erg = (e.von && !s_blank) ? {s_red, s_green, s_blue} : 6'd0;
      checks++;
      if (s_obs !== e || s_rgb !== erg) begin
        errors++;
        $display("FAIL midline_model k=%0d got %h/%h exp %h/%h", k, s_obs, s_rgb, e, erg);
      end
      if (k < 35) rand_small();
    end
    // Outputs now show pixel (5,2); reset is applied between clock edges.
    s_reset = 1'b0;
    #1;
    e = reset_vals(1'b0, 1'b0);
    checks++;
    if (s_obs !== e || s_rgb !== 6'd0) begin
      errors++;
      $display("FAIL midline_async_reset got %h/%h exp %h/0", s_obs, s_rgb, e);
    end
    @(negedge clk);
    checks++;
    if (s_obs !== e || s_rgb !== 6'd0) begin
      errors++;
      $display("FAIL midline_reset_hold got %h/%h exp %h/0", s_obs, s_rgb, e);
    end
    rand_small();
    s_reset = 1'b1;
    @(negedge clk);
    e   = model_small(0);
    erg = {s_red, s_green, s_blue};
    checks++;
    if (s_obs !== e || s_frame_start !== 1'b1 || s_rgb !== erg) begin
      errors++;
      $display("FAIL midline_restart got %h/%h exp %h/%h", s_obs, s_rgb, e, erg);
    end
  endtask

  task automatic test_polarity();
    tim_t       e;
    logic [5:0] erg;
    int         hs_hi = 0;
    int         vs_hi = 0;
    @(negedge clk);
    p_red = 2'd3; p_green = 2'd1; p_blue = 2'd2; p_blank = 1'b0;
    p_reset = 1'b1;
    for (int k = 0; k < 630; k++) begin
      @(negedge clk);
      e   = model_pol(k);
      erg = (e.von && !p_blank) ? {p_red, p_green, p_blue} : 6'd0;
      checks++;
      if (p_obs !== e || p_rgb !== erg) begin
        errors++;
        $display("FAIL pol_model k=%0d got %h/%h exp %h/%h", k, p_obs, p_rgb, e, erg);
      end
      if (k < 315 && p_hsync === 1'b1) hs_hi++;
      if (k < 315 && p_vsync === 1'b1) vs_hi++;
      p_red   = 2'($urandom_range(0, 3));
      p_green = 2'($urandom_range(0, 3));
      p_blue  = 2'($urandom_range(0, 3));
      p_blank = ($urandom_range(0, 3) == 0);
    end
    // 3 sync pixels x 7 lines x 3 clks; 1 sync line x 15 pixels x 3 clks.
    checks++;
    if (hs_hi !== 63 || vs_hi !== 45) begin
      errors++;
      $display("FAIL pol_sync_counts got hs %0d vs %0d exp hs 63 vs 45", hs_hi, vs_hi);
    end
    p_reset = 1'b0;
    #1;
    checks++;
    if (p_hsync !== 1'b0 || p_vsync !== 1'b0 || p_rgb !== 6'd0) begin
      errors++;
      $display("FAIL pol_reset_idle got hs %b vs %b rgb %h exp 0 0 0", p_hsync, p_vsync, p_rgb);
    end
  endtask

  initial begin
    test_reset();
    test_default_line();
    test_small_frame();
    test_blank();
    test_reset_midline();
    test_polarity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal front porch / sync / back porch in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical porches / sync in lines.
REQ-005 SHALL have parameter CLK_DIV, default 4, clk cycles per pixel (legal range 1..16).
REQ-006 SHALL have parameter COLOR_W, default 1, bits per colour channel.
REQ-007 SHALL have parameters HS_POL / VS_POL, default 0 / 0, active level of hsync / vsync.
REQ-008 SHALL have port clk, input, 1, single system clock; all logic on rising edge.
REQ-009 SHALL have port reset, input, 1; reset is asynchronous and active-low.
REQ-010 SHALL have ports red / green / blue, input, COLOR_W each, pixel colour for the current position.
REQ-011 SHALL have port blank, input, 1, forces rgb to zero when high; timing unaffected.
REQ-012 SHALL have ports hsync / vsync, output, 1 each, sync pulses at HS_POL / VS_POL.
REQ-013 SHALL have port rgb, output, 3*COLOR_W, packed {red,green,blue}.
REQ-014 SHALL have ports pixel_x / pixel_y, output, 10 each, current horizontal / vertical count.
REQ-015 SHALL have ports video_on, pixel_tick, line_start, frame_start, output, 1 each.

Function
REQ-016 SHALL hold a prescaler counting 0..CLK_DIV-1 and wrapping; the internal tick is high when prescaler == CLK_DIV-1 (every clk when CLK_DIV=1).
REQ-017 SHALL advance h_cnt on each tick, wrapping from H_TOTAL-1 to 0, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
REQ-018 SHALL advance v_cnt only on a tick where h_cnt wraps, wrapping from V_TOTAL-1 to 0 (both wraps on the same tick give (0,0)).
REQ-019 SHALL decode video_on = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
REQ-020 SHALL drive hsync = HS_POL iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL; vsync analogous on v_cnt with V parameters and VS_POL.
REQ-021 SHALL register every output in a single output stage updated on every clk: pixel_x, pixel_y, hsync, vsync and video_on reflect the counter values of the previous clk (1-clk latency, all mutually aligned).
REQ-022 SHALL register rgb = {red,green,blue} when decoded video_on && !blank, else 0, with 1-clk latency from the inputs.
REQ-023 SHALL pulse pixel_tick for one clk, aligned with the output stage, on the first clk of each pixel (prescaler == 0).
REQ-024 SHALL pulse line_start for one clk when h_cnt == 0 and prescaler == 0; frame_start additionally requires v_cnt == 0.
REQ-025 SHALL zero-extend counters into 10-bit pixel_x / pixel_y; H_TOTAL and V_TOTAL above 1024 are illegal and SHALL be rejected at elaboration.

Reset
REQ-026 SHALL, while reset is low, force prescaler, h_cnt and v_cnt to 0, and force pixel_x = 0, pixel_y = 0, hsync = ~HS_POL, vsync = ~VS_POL, rgb = 0, video_on = 0, pixel_tick = 0, line_start = 0, frame_start = 0.
REQ-027 SHALL, on the first clk after reset release, present position (0,0) with video_on = 1, pixel_tick = 1, line_start = 1 and frame_start = 1.
REQ-028 SHALL, when reset is asserted mid-frame, return all state to the REQ-026 values immediately, with no partial-line completion.

Structure
REQ-029 SHALL source the default 640x480@60 timing constants and derived H_TOTAL / V_TOTAL from shared package vga_pkg.
REQ-030 SHALL instantiate sub-module vga_axis_counter (parameterised wrap counter with enable in and carry out) twice, for h_cnt and for v_cnt.

Verification
REQ-031 SHALL check defaults, CLK_DIV=4: hsync low for exactly 384 clks, line period 3200 clks, frame period 1,680,000 clks, vsync low for 6400 clks.
REQ-032 SHALL check reduced timing H 8/2/3/2, V 4/1/1/1, CLK_DIV=1: the frame_start period is exactly 105 clks; hsync is active at pixel_x 10..12; video_on is high for 32 clks per frame.
REQ-033 SHALL apply random red/green/blue with COLOR_W=2 and check that rgb equals the previous-clk inputs inside the active area and is 0 in the porches.
REQ-034 SHALL hold blank high for one full line and check that rgb stays 0 while hsync, vsync and the counters are unchanged against a reference model.
REQ-035 SHALL assert reset at pixel (5,2) mid-line and check that outputs take the REQ-026 values asynchronously, then frame_start = 1 on the first clk after release.
REQ-036 SHALL set HS_POL = 1 and VS_POL = 1 and check that the sync outputs are inverted and that the idle level during reset is 0.
